// File: rtl/usb_tx_encoder.sv
// Full-speed USB transmit line encoder.
// Accepts packet bytes over valid/ready and drives SYNC, NRZI-encoded and
// bit-stuffed data (LSB first), then EOP on d_plus/d_minus. Bit periods run
// 8,8,9 clocks so that three bits take 25 clocks.
module usb_tx_encoder #(
  parameter logic [7:0] SYNC_BYTE = 8'h80
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_byte,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       d_plus,
  output logic       d_minus,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_STUFF,
    ST_EOP_SE0,
    ST_EOP_J
  } state_t;

  // How the line registers change at the end of a cycle
  typedef enum logic [2:0] {
    LN_KEEP,
    LN_START,
    LN_BIT,
    LN_SE0,
    LN_J
  } line_op_t;

  state_t     state_q;
  state_t     state_d;

  // Bit timer
  logic [3:0] cyc_cnt;
  logic [1:0] phase;
  logic       bit_tick;

  // Datapath
  logic [2:0] bit_idx;
  logic [7:0] shifter;
  logic       cur_last;
  logic [7:0] hold_byte;
  logic       hold_full;
  logic       hold_last;
  logic       last_accepted;
  logic [2:0] ones_count;
  logic       resume_boundary;
  logic       eop_second;
  logic       run_q;

  // Combinational control
  logic       accept;
  logic       cur_bit;
  logic [2:0] ones_next;
  logic       at_boundary;
  line_op_t   line_op;
  logic       nxt_bit;
  logic       load_hold;
  logic       load_byp;
  logic       adv_bit;
  logic       shift_en;
  logic       enter_stuff;
  logic       set_err;
  logic       set_done;

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Bit currently on the line and the run length it produces
  always_comb begin
    cur_bit = 1'b0;
    case (state_q)
      ST_SYNC: cur_bit = SYNC_BYTE[bit_idx];
      ST_DATA: cur_bit = shifter[0];
      default: cur_bit = 1'b0;
    endcase
    ones_next = cur_bit ? (ones_count + 3'd1) : '0;
  end

  // Next-state and per-tick control decisions
  always_comb begin
    state_d     = state_q;
    line_op     = LN_KEEP;
    nxt_bit     = 1'b1;
    at_boundary = 1'b0;
    load_hold   = 1'b0;
    load_byp    = 1'b0;
    adv_bit     = 1'b0;
    shift_en    = 1'b0;
    enter_stuff = 1'b0;
    set_err     = 1'b0;
    set_done    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_SYNC;
          line_op = LN_START;
        end
      end
      ST_SYNC: begin
        if (bit_tick) begin
          if (bit_idx != 3'd7) begin
            adv_bit = 1'b1;
            nxt_bit = SYNC_BYTE[bit_idx + 3'd1];
            line_op = LN_BIT;
          end else begin
            at_boundary = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (bit_tick) begin
          adv_bit  = 1'b1;
          shift_en = 1'b1;
          if (ones_next == 3'd6) begin
            state_d     = ST_STUFF;
            enter_stuff = 1'b1;
            nxt_bit     = 1'b0;
            line_op     = LN_BIT;
          end else if (bit_idx != 3'd7) begin
            nxt_bit = shifter[1];
            line_op = LN_BIT;
          end else begin
            at_boundary = 1'b1;
          end
        end
      end
      ST_STUFF: begin
        if (bit_tick) begin
          if (resume_boundary) begin
            at_boundary = 1'b1;
          end else begin
            // shifter already advanced past the bit that triggered the stuff
            state_d = ST_DATA;
            nxt_bit = shifter[0];
            line_op = LN_BIT;
          end
        end
      end
      ST_EOP_SE0: begin
        if (bit_tick && eop_second) begin
          state_d = ST_EOP_J;
          line_op = LN_J;
        end
      end
      ST_EOP_J: begin
        if (bit_tick) begin
          state_d  = ST_IDLE;
          set_done = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Byte boundary: next byte from the holding register, directly from the
    // input on a coincident handshake, or end the packet
    if (at_boundary) begin
      if (hold_full) begin
        load_hold = 1'b1;
        nxt_bit   = hold_byte[0];
        state_d   = ST_DATA;
        line_op   = LN_BIT;
      end else if (accept) begin
        load_byp = 1'b1;
        nxt_bit  = tx_byte[0];
        state_d  = ST_DATA;
        line_op  = LN_BIT;
      end else begin
        state_d = ST_EOP_SE0;
        line_op = LN_SE0;
        set_err = !cur_last;
      end
    end
  end

  // Handshake and status outputs from registered state
  always_comb begin
    tx_busy  = (state_q != ST_IDLE);
    tx_ready = run_q && !hold_full && !last_accepted &&
               (state_q inside {ST_IDLE, ST_SYNC, ST_DATA, ST_STUFF});
    accept   = tx_valid && tx_ready;
    bit_tick = tx_busy && (cyc_cnt == ((phase == 2'd2) ? 4'd8 : 4'd7));
  end

  // 8,8,9 bit timer; held cleared while idle so each packet starts in phase
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cyc_cnt <= '0;
      phase   <= '0;
    end else if (state_q == ST_IDLE) begin
      cyc_cnt <= '0;
      phase   <= '0;
    end else if (bit_tick) begin
      cyc_cnt <= '0;
      phase   <= (phase == 2'd2) ? 2'd0 : (phase + 2'd1);
    end else begin
      cyc_cnt <= cyc_cnt + 4'd1;
    end
  end

  // Holding register, shifter, stuffing and EOP bookkeeping
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      run_q           <= 1'b0;
      bit_idx         <= '0;
      shifter         <= '0;
      cur_last        <= 1'b0;
      hold_byte       <= '0;
      hold_full       <= 1'b0;
      hold_last       <= 1'b0;
      last_accepted   <= 1'b0;
      ones_count      <= '0;
      resume_boundary <= 1'b0;
      eop_second      <= 1'b0;
    end else begin
      run_q <= 1'b1;

      if (state_q == ST_IDLE || load_hold || load_byp) begin
        bit_idx <= '0;
      end else if (adv_bit) begin
        bit_idx <= bit_idx + 3'd1;
      end

      if (load_hold) begin
        shifter  <= hold_byte;
        cur_last <= hold_last;
      end else if (load_byp) begin
        shifter  <= tx_byte;
        cur_last <= tx_last;
      end else if (shift_en) begin
        shifter <= {1'b0, shifter[7:1]};
      end

      if (load_hold) begin
        hold_full <= 1'b0;
      end
      if (accept && !load_byp) begin
        hold_byte <= tx_byte;
        hold_last <= tx_last;
        hold_full <= 1'b1;
      end

      if (set_done) begin
        last_accepted <= 1'b0;
      end else if (accept && tx_last) begin
        last_accepted <= 1'b1;
      end

      if (state_q == ST_IDLE) begin
        ones_count <= '0;
      end else if (bit_tick) begin
        ones_count <= ones_next;
      end

      if (enter_stuff) begin
        resume_boundary <= (bit_idx == 3'd7);
      end

      if (state_q != ST_EOP_SE0) begin
        eop_second <= 1'b0;
      end else if (bit_tick) begin
        eop_second <= 1'b1;
      end
    end
  end

  // Registered line drivers and completion pulses
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      d_plus   <= 1'b1;
      d_minus  <= 1'b0;
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
    end else begin
      tx_done  <= set_done;
      tx_error <= set_err;
      case (line_op)
        LN_START: {d_plus, d_minus} <= SYNC_BYTE[0] ? 2'b10 : 2'b01;
        LN_BIT: begin
          if (!nxt_bit) begin
            {d_plus, d_minus} <= {d_minus, d_plus};
          end
        end
        LN_SE0:  {d_plus, d_minus} <= 2'b00;
        LN_J:    {d_plus, d_minus} <= 2'b10;
        default: {d_plus, d_minus} <= {d_plus, d_minus};
      endcase
    end
  end

endmodule

// File: tb/tb_usb_tx_encoder.sv
// Self-checking bench for usb_tx_encoder: a line-level model pushes the
// expected per-cycle {d_plus, d_minus, tx_busy, tx_done, tx_error} for each
// packet; a negedge monitor pops and compares while the packet runs.
module tb_usb_tx_encoder;

  localparam logic [1:0] LJ   = 2'b10;
  localparam logic [1:0] LSE0 = 2'b00;
  localparam int         LIMIT = 3000;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       tx_valid;
  logic [7:0] tx_byte;
  logic       tx_last;
  logic       tx_ready;
  logic       d_plus;
  logic       d_minus;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_error;

  logic [4:0] exp_q[$];
  int         checks = 0;
  int         errors = 0;
  bit         mon_en = 1'b0;
  bit         started = 1'b0;
  int         cyc_no = 0;

  usb_tx_encoder #(.SYNC_BYTE(8'h80)) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .tx_valid (tx_valid),
    .tx_byte  (tx_byte),
    .tx_last  (tx_last),
    .tx_ready (tx_ready),
    .d_plus   (d_plus),
    .d_minus  (d_minus),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done),
    .tx_error (tx_error)
  );

  always #5 clk = ~clk;

  // Model one packet: SYNC, stuffed NRZI data, SE0 SE0 J, then the done cycle
  task automatic push_pkt(input logic [7:0] b0, input logic [7:0] b1,
                          input int n, input bit underrun, output int ncyc);
    logic [7:0] syncv;
    logic [7:0] cur;
    logic [1:0] line;
    logic [1:0] per[$];
    int         ones;
    int         se0_idx;
    int         len;
    syncv = 8'h80;
    line  = LJ;
    ones  = 0;
    ncyc  = 0;
    for (int i = 0; i < 8; i++) begin
      if (!syncv[i]) line = ~line;
      per.push_back(line);
      ones = syncv[i] ? ones + 1 : 0;
    end
    for (int k = 0; k < n; k++) begin
      cur = (k == 0) ? b0 : b1;
      for (int i = 0; i < 8; i++) begin
        if (!cur[i]) line = ~line;
        per.push_back(line);
        ones = cur[i] ? ones + 1 : 0;
        if (ones == 6) begin
          line = ~line;
          per.push_back(line);
          ones = 0;
        end
      end
    end
    se0_idx = per.size();
    per.push_back(LSE0);
    per.push_back(LSE0);
    per.push_back(LJ);
    for (int p = 0; p < per.size(); p++) begin
      len = (p % 3 == 2) ? 9 : 8;
      for (int c = 0; c < len; c++) begin
        exp_q.push_back({per[p], 1'b1, 1'b0, (underrun && p == se0_idx && c == 0)});
        ncyc++;
      end
    end
    exp_q.push_back({LJ, 1'b0, 1'b1, 1'b0});
  endtask

  // Present a byte from a negedge; returns at the negedge after the handshake
  task automatic send(input logic [7:0] b, input logic last, output int waited);
    waited   = 0;
    tx_valid = 1'b1;
    tx_byte  = b;
    tx_last  = last;
    while (!tx_ready && waited < LIMIT) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    assert (waited < LIMIT) else begin
      errors++;
      $error("FAIL handshake_timeout waited=%0d limit=%0d", waited, LIMIT);
    end
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL packet_drain left=%0d required=0", exp_q.size());
    end
    exp_q.delete();
    repeat (3) @(negedge clk);
  endtask

  // Scoreboard monitor: packet cycles against the model, idle cycles against J/quiet
  always @(negedge clk) begin
    logic [4:0] obs;
    logic [4:0] e;
    cyc_no++;
    obs = {d_plus, d_minus, tx_busy, tx_done, tx_error};
    if (mon_en) begin
      if (exp_q.size() != 0 && (started || tx_busy)) begin
        started = 1'b1;
        e = exp_q.pop_front();
        checks++;
        assert (obs === e) else begin
          errors++;
          $error("FAIL pkt_cycle t=%0d observed=%b required=%b", cyc_no, obs, e);
        end
        if (exp_q.size() == 0) started = 1'b0;
      end else begin
        checks++;
        assert (obs === 5'b10000) else begin
          errors++;
          $error("FAIL idle_cycle t=%0d observed=%b required=%b", cyc_no, obs, 5'b10000);
        end
      end
    end
  end

  initial begin
    int w;
    int n1;
    int n2;
    n_rst    = 1'b0;
    tx_valid = 1'b0;
    tx_byte  = '0;
    tx_last  = 1'b0;
    repeat (3) @(negedge clk);

    checks++;
    assert ({d_plus, d_minus, tx_ready, tx_busy, tx_done, tx_error} === 6'b100000) else begin
      errors++;
      $error("FAIL reset_state observed=%b required=%b",
             {d_plus, d_minus, tx_ready, tx_busy, tx_done, tx_error}, 6'b100000);
    end
    n_rst = 1'b1;
    @(negedge clk);
    checks++;
    assert (tx_ready === 1'b1) else begin
      errors++;
      $error("FAIL idle_ready observed=%b required=1", tx_ready);
    end
    mon_en = 1'b1;

    // Single zero byte: every data bit toggles, 158-cycle packet
    push_pkt(8'h00, 8'h00, 1, 1'b0, n1);
    send(8'h00, 1'b1, w);
    wait_drain();

    // 0xFF: one stuffed bit after six consecutive ones
    push_pkt(8'hFF, 8'h00, 1, 1'b0, n1);
    send(8'hFF, 1'b1, w);
    wait_drain();

    // Two bytes through the holding register; ready returns at first data cycle
    push_pkt(8'hA5, 8'h3C, 2, 1'b0, n1);
    send(8'hA5, 1'b0, w);
    send(8'h3C, 1'b1, w);
    checks++;
    assert (w == 66) else begin
      errors++;
      $error("FAIL ready_reassert waited=%0d required=66", w);
    end
    wait_drain();

    // Stuffed bit right before EOP
    push_pkt(8'hFC, 8'h00, 1, 1'b0, n1);
    send(8'hFC, 1'b1, w);
    wait_drain();

    // Stuffed bit at a byte boundary, then the held byte resumes
    push_pkt(8'hFC, 8'h81, 2, 1'b0, n1);
    send(8'hFC, 1'b0, w);
    send(8'h81, 1'b1, w);
    wait_drain();

    // Stuffing run across a byte boundary
    push_pkt(8'hF0, 8'h0F, 2, 1'b0, n1);
    send(8'hF0, 1'b0, w);
    send(8'h0F, 1'b1, w);
    wait_drain();

    // Underrun: error with the first SE0, then EOP and done
    push_pkt(8'h12, 8'h00, 1, 1'b1, n1);
    send(8'h12, 1'b0, w);
    wait_drain();

    // Second byte offered exactly on the boundary tick (cycle 132): bypass load
    push_pkt(8'h12, 8'h34, 2, 1'b0, n1);
    send(8'h12, 1'b0, w);
    repeat (132) @(negedge clk);
    send(8'h34, 1'b1, w);
    checks++;
    assert (w == 0) else begin
      errors++;
      $error("FAIL bypass_ready waited=%0d required=0", w);
    end
    wait_drain();

    // Reset in the middle of DATA, then a clean packet
    mon_en = 1'b0;
    send(8'h00, 1'b1, w);
    repeat (90) @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    checks++;
    assert ({d_plus, d_minus, tx_ready, tx_busy, tx_done, tx_error} === 6'b100000) else begin
      errors++;
      $error("FAIL async_reset observed=%b required=%b",
             {d_plus, d_minus, tx_ready, tx_busy, tx_done, tx_error}, 6'b100000);
    end
    @(negedge clk);
    n_rst = 1'b1;
    exp_q.delete();
    started = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
    push_pkt(8'h00, 8'h00, 1, 1'b0, n1);
    send(8'h00, 1'b1, w);
    wait_drain();

    // tx_valid held after tx_last: ready only in IDLE, next SYNC follows at once
    push_pkt(8'h7E, 8'h00, 1, 1'b0, n1);
    push_pkt(8'h00, 8'h00, 1, 1'b0, n2);
    send(8'h7E, 1'b1, w);
    send(8'h00, 1'b1, w);
    checks++;
    assert (w == n1) else begin
      errors++;
      $error("FAIL ready_after_last waited=%0d required=%0d", w, n1);
    end
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
